// File: rtl/home_evt_pkg.sv
// rtl/home_evt_pkg.sv - event codes, seven-segment patterns and FSM states shared by the annunciator
package home_evt_pkg;

    localparam logic [2:0] EVT_NONE   = 3'd0;
    localparam logic [2:0] EVT_FRONT  = 3'd1;
    localparam logic [2:0] EVT_REAR   = 3'd2;
    localparam logic [2:0] EVT_FIRE   = 3'd3;
    localparam logic [2:0] EVT_WINDOW = 3'd4;
    localparam logic [2:0] EVT_COLD   = 3'd5;
    localparam logic [2:0] EVT_HOT    = 3'd6;

    // {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam logic [6:0] SEG_FRONT  = 7'b0110000;
    localparam logic [6:0] SEG_REAR   = 7'b1101101;
    localparam logic [6:0] SEG_FIRE   = 7'b1111001;
    localparam logic [6:0] SEG_WINDOW = 7'b0110011;
    localparam logic [6:0] SEG_COLD   = 7'b1011011;
    localparam logic [6:0] SEG_HOT    = 7'b1011111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [6:0] seg_of(input logic [2:0] code);
        case (code)
            EVT_FRONT:  seg_of = SEG_FRONT;
            EVT_REAR:   seg_of = SEG_REAR;
            EVT_FIRE:   seg_of = SEG_FIRE;
            EVT_WINDOW: seg_of = SEG_WINDOW;
            EVT_COLD:   seg_of = SEG_COLD;
            EVT_HOT:    seg_of = SEG_HOT;
            default:    seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - synchronous event FIFO; a push into a full queue is accepted only alongside a pop
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/home_event_annunciator.sv
// rtl/home_event_annunciator.sv - dedups monitor codes into events, queues and shows them, counts per code
// Optional FIRE_PREEMPT_EN: fire events use a one-entry priority slot and cut the current hold short.
module home_event_annunciator #(
    parameter int HOLD_CYCLES = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ROUND_LEN   = 5,
    parameter int CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [2:0]       display,
    input  logic             clr_cnt,
    input  logic             ack,
    input  logic [2:0]       cnt_sel,
    output logic [6:0]       seg,
    output logic [2:0]       cur_code,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] cnt_out
);
    import home_evt_pkg::*;

    localparam int AGE_W  = $clog2(ROUND_LEN + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        cur_q, cur_d;
    logic [6:1]        seen_q, seen_d;
    logic [AGE_W-1:0]  age_q [1:6];
    logic [AGE_W-1:0]  age_d [1:6];
    logic [CNT_W-1:0]  cnt_q [1:6];
    logic [CNT_W-1:0]  cnt_d [1:6];
    logic              overflow_q, overflow_d;
    logic              evt, drop;
    logic [2:0]        evt_code, fifo_head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
`ifdef FIRE_PREEMPT_EN
    logic              fire_pend_q, fire_pend_d, fire_take;
`endif

    evt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
        .Clk(Clk), .Rst(Rst), .push(fifo_push), .push_data(evt_code),
        .pop(fifo_pop), .head(fifo_head), .full(fifo_full), .empty(fifo_empty)
    );

    // A code stays armed until it has been absent for ROUND_LEN consecutive samples.
    always_comb begin
        seen_d   = seen_q;
        age_d    = age_q;
        evt      = 1'b0;
        evt_code = EVT_NONE;
        for (int i = 1; i <= 6; i++) begin
            if (display == 3'(i)) begin
                if (!seen_q[i]) begin
                    evt      = 1'b1;
                    evt_code = 3'(i);
                end
                seen_d[i] = 1'b1;
                age_d[i]  = '0;
            end else if (age_q[i] != AGE_W'(ROUND_LEN)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
                if (age_q[i] == AGE_W'(ROUND_LEN - 1)) seen_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cur_d    = cur_q;
        fifo_pop = 1'b0;
`ifdef FIRE_PREEMPT_EN
        fire_take = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FIRE_PREEMPT_EN
                if (fire_pend_q) begin
                    fire_take = 1'b1;
                    cur_d     = EVT_FIRE;
                    hold_d    = HOLD_W'(HOLD_CYCLES);
                    state_d   = ST_SHOW;
                end else
`endif
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_head;
                    hold_d   = HOLD_W'(HOLD_CYCLES);
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) state_d = ST_GAP;
`ifdef FIRE_PREEMPT_EN
                if (fire_pend_q && cur_q != EVT_FIRE) state_d = ST_GAP;
`endif
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        fifo_push = 1'b0;
        drop      = 1'b0;
`ifdef FIRE_PREEMPT_EN
        fire_pend_d = fire_pend_q && !fire_take;
        if (evt && evt_code == EVT_FIRE) begin
            if (fire_pend_q && !fire_take) drop = 1'b1;
            else                           fire_pend_d = 1'b1;
        end else begin
            fifo_push = evt;
        end
`else
        fifo_push = evt;
`endif
        if (fifo_push && fifo_full && !fifo_pop) drop = 1'b1;
        // Counters track every event, including ones dropped from the queue.
        for (int i = 1; i <= 6; i++) begin
            if (clr_cnt) begin
                cnt_d[i] = '0;
            end else if (evt && evt_code == 3'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        overflow_d = drop ? 1'b1 : (ack ? 1'b0 : overflow_q);
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 1; i <= 6; i++) begin
            if (cnt_sel == 3'(i)) cnt_out = cnt_q[i];
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign cur_code = (state_q == ST_SHOW) ? cur_q : EVT_NONE;
    assign seg      = seg_of(cur_code);
    assign overflow = overflow_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            cur_q      <= EVT_NONE;
            seen_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 1; i <= 6; i++) begin
                age_q[i] <= '0;
                cnt_q[i] <= '0;
            end
`ifdef FIRE_PREEMPT_EN
            fire_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cur_q      <= cur_d;
            seen_q     <= seen_d;
            overflow_q <= overflow_d;
            age_q      <= age_d;
            cnt_q      <= cnt_d;
`ifdef FIRE_PREEMPT_EN
            fire_pend_q <= fire_pend_d;
`endif
        end
    end

endmodule
